// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer scanout pipeline.
package fb_pkg;

  typedef enum logic [1:0] {
    FMT_RGB332 = 2'd0,
    FMT_RGB565 = 2'd1,
    FMT_GREY4  = 2'd2,
    FMT_RSVD   = 2'd3
  } fb_mode_e;

  localparam int unsigned LANES_RGB332 = 4;
  localparam int unsigned LANES_RGB565 = 2;
  localparam int unsigned LANES_GREY4  = 8;
  localparam int unsigned LANE_W       = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Per-pixel side information that travels beside the memory read.
  typedef struct packed {
    logic [LANE_W-1:0] lane;
    fb_mode_e          mode;
    logic              in_range;
    logic              active;
    logic              h_sync;
    logic              v_sync;
  } pix_tag_t;

  // log2 of pixels per 32-bit word; the reserved mode reuses the RGB332 split.
  function automatic logic [1:0] lane_log2(fb_mode_e m);
    logic [1:0] v;
    case (m)
      FMT_RGB565: v = 2'($clog2(LANES_RGB565));
      FMT_GREY4:  v = 2'($clog2(LANES_GREY4));
      default:    v = 2'($clog2(LANES_RGB332));
    endcase
    return v;
  endfunction

  function automatic logic [LANE_W-1:0] lane_mask(fb_mode_e m);
    return LANE_W'((32'd1 << lane_log2(m)) - 32'd1);
  endfunction

endpackage

// File: rtl/fb_scanout_expand.sv
// Lane select and bit-replicating colour expansion for one framebuffer word.
module fb_pixel_expand
  import fb_pkg::*;
(
  input  logic [31:0]       i_rdata,
  input  logic [LANE_W-1:0] i_lane,
  input  fb_mode_e          i_mode,
  output rgb24_t            o_rgb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_nib;

  assign w_byte = 8'(i_rdata >> {i_lane[1:0], 3'b000});
  assign w_half = 16'(i_rdata >> {i_lane[0], 4'b0000});
  assign w_nib  = 4'(i_rdata >> {i_lane, 2'b00});

  always_comb begin
    o_rgb = '0;
    case (i_mode)
      FMT_RGB332: begin
        o_rgb.r = {w_byte[7:5], w_byte[7:5], w_byte[7:6]};
        o_rgb.g = {w_byte[4:2], w_byte[4:2], w_byte[4:3]};
        o_rgb.b = {4{w_byte[1:0]}};
      end
      FMT_RGB565: begin
        o_rgb.r = {w_half[15:11], w_half[15:13]};
        o_rgb.g = {w_half[10:5], w_half[10:9]};
        o_rgb.b = {w_half[4:0], w_half[4:2]};
      end
      FMT_GREY4: begin
        o_rgb.r = {w_nib, w_nib};
        o_rgb.g = {w_nib, w_nib};
        o_rgb.b = {w_nib, w_nib};
      end
      default: o_rgb = '0;
    endcase
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: video timing -> word reads -> 24-bit RGB, fixed latency 3+RD_LATENCY.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH        = 320,
  parameter int unsigned FB_HEIGHT       = 180,
  parameter int unsigned SCALE_LOG2      = 2,
  parameter logic [31:0] FB_BASE_DEFAULT = 32'h300,
  parameter int unsigned RD_LATENCY      = 2,
  parameter logic [23:0] BORDER_RGB      = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_in,
  input  logic [31:0] fb_base_in,
  input  logic [10:0] h_count_in,
  input  logic [9:0]  v_count_in,
  input  logic        active_draw_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        new_frame_in,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        active_draw_out,
  output logic        h_sync_out,
  output logic        v_sync_out
);

  // Shadow registers: software may change mode/base at any time, the pipeline
  // only sees them at a frame start.
  fb_mode_e    r_shadow_mode;
  logic [31:0] r_shadow_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_mode <= FMT_RGB332;
      r_shadow_base <= FB_BASE_DEFAULT;
    end else if (new_frame_in) begin
      r_shadow_mode <= fb_mode_e'(mode_in);
      r_shadow_base <= fb_base_in;
    end
  end

  // Stage 1: framebuffer coordinates and linear pixel index.
  logic [31:0] w_fb_x;
  logic [31:0] w_fb_y;
  logic [31:0] w_idx;
  logic        w_in_range;

  assign w_fb_x     = {21'd0, h_count_in} >> SCALE_LOG2;
  assign w_fb_y     = {22'd0, v_count_in} >> SCALE_LOG2;
  assign w_in_range = (w_fb_x < FB_WIDTH) && (w_fb_y < FB_HEIGHT);
  assign w_idx      = w_fb_y * FB_WIDTH + w_fb_x;

  logic [31:0] r1_idx;
  logic [31:0] r1_base;
  fb_mode_e    r1_mode;
  logic        r1_in_range;
  logic        r1_active;
  logic        r1_hs;
  logic        r1_vs;

  // Mode and base are sampled with the pixel so a frame switch lands on an exact pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_idx      <= '0;
      r1_base     <= '0;
      r1_mode     <= FMT_RGB332;
      r1_in_range <= 1'b0;
      r1_active   <= 1'b0;
      r1_hs       <= 1'b0;
      r1_vs       <= 1'b0;
    end else begin
      r1_idx      <= w_idx;
      r1_base     <= r_shadow_base;
      r1_mode     <= r_shadow_mode;
      r1_in_range <= w_in_range;
      r1_active   <= active_draw_in;
      r1_hs       <= h_sync_in;
      r1_vs       <= v_sync_in;
    end
  end

  // Stage 2: word address and lane within the word.
  logic [31:0]       w_word_off;
  logic [LANE_W-1:0] w_lane;
  pix_tag_t          w_tag2;

  assign w_word_off = r1_idx >> lane_log2(r1_mode);
  assign w_lane     = r1_idx[LANE_W-1:0] & lane_mask(r1_mode);

  always_comb begin
    w_tag2          = '0;
    w_tag2.lane     = w_lane;
    w_tag2.mode     = r1_mode;
    w_tag2.in_range = r1_in_range;
    w_tag2.active   = r1_active;
    w_tag2.h_sync   = r1_hs;
    w_tag2.v_sync   = r1_vs;
  end

  logic [31:0] r_mem_addr;
  pix_tag_t    r2_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr <= '0;
      r2_tag     <= '0;
    end else begin
      r_mem_addr <= r1_base + w_word_off;
      r2_tag     <= w_tag2;
    end
  end

  assign mem_addr = r_mem_addr;

  // Side information waits RD_LATENCY cycles so it meets the returning word.
  pix_tag_t r_dly [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= r2_tag;
      for (int i = 1; i < RD_LATENCY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // Output stage.
  pix_tag_t w_tag_o;
  rgb24_t   w_exp_rgb;
  rgb24_t   w_rgb_next;

  assign w_tag_o = r_dly[RD_LATENCY-1];

  fb_pixel_expand u_expand (
    .i_rdata (mem_rdata),
    .i_lane  (w_tag_o.lane),
    .i_mode  (w_tag_o.mode),
    .o_rgb   (w_exp_rgb)
  );

  always_comb begin
    w_rgb_next = w_exp_rgb;
    if (!w_tag_o.active) begin
      w_rgb_next = '0;
    end else if (!w_tag_o.in_range || (w_tag_o.mode == FMT_RSVD)) begin
      w_rgb_next = rgb24_t'(BORDER_RGB);
    end
  end

  rgb24_t r_rgb;
  logic   r_active;
  logic   r_hs;
  logic   r_vs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb    <= '0;
      r_active <= 1'b0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
    end else begin
      r_rgb    <= w_rgb_next;
      r_active <= w_tag_o.active;
      r_hs     <= w_tag_o.h_sync;
      r_vs     <= w_tag_o.v_sync;
    end
  end

  assign red             = r_rgb.r;
  assign green           = r_rgb.g;
  assign blue            = r_rgb.b;
  assign active_draw_out = r_active;
  assign h_sync_out      = r_hs;
  assign v_sync_out      = r_vs;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: directed steps plus random timing, checked against a behavioural model.
module tb_fb_scanout;

  localparam int unsigned FB_W   = 320;
  localparam int unsigned FB_H   = 160;
  localparam int unsigned SCALE  = 2;
  localparam int unsigned RDL    = 2;
  localparam logic [31:0] BASE0  = 32'h300;
  localparam logic [23:0] BORDER = 24'h123456;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_in = '0;
  logic [31:0] fb_base_in = '0;
  logic [10:0] h_count_in = '0;
  logic [9:0]  v_count_in = '0;
  logic        active_draw_in = 1'b0;
  logic        h_sync_in = 1'b0;
  logic        v_sync_in = 1'b0;
  logic        new_frame_in = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  red, green, blue;
  logic        active_draw_out, h_sync_out, v_sync_out;

  fb_scanout #(
    .FB_WIDTH        (FB_W),
    .FB_HEIGHT       (FB_H),
    .SCALE_LOG2      (SCALE),
    .FB_BASE_DEFAULT (BASE0),
    .RD_LATENCY      (RDL),
    .BORDER_RGB      (BORDER)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mode_in         (mode_in),
    .fb_base_in      (fb_base_in),
    .h_count_in      (h_count_in),
    .v_count_in      (v_count_in),
    .active_draw_in  (active_draw_in),
    .h_sync_in       (h_sync_in),
    .v_sync_in       (v_sync_in),
    .new_frame_in    (new_frame_in),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .active_draw_out (active_draw_out),
    .h_sync_out      (h_sync_out),
    .v_sync_out      (v_sync_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          addr_chk;
    bit          in_range;
    int          lane;
    int          mode;
    bit          ad;
    bit          hs;
    bit          vs;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] hist[$];
  logic [31:0] mem [4096];
  int          n_assert = 0;
  int          n_fail = 0;
  int          m_mode = 0;
  logic [31:0] m_base = BASE0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return mem[a[11:0]];
  endfunction

  function automatic rec_t zero_rec();
    rec_t e;
    e.addr = 32'h0; e.addr_chk = 1'b1; e.in_range = 1'b0; e.lane = 0;
    e.mode = 0; e.ad = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
    return e;
  endfunction

  function automatic rec_t model_rec(int h, int v, bit ad, bit hs, bit vs);
    rec_t e;
    int fx, fy, lanes;
    int unsigned idx;
    fx = h >> SCALE;
    fy = v >> SCALE;
    lanes = (m_mode == 1) ? 2 : (m_mode == 2) ? 8 : 4;
    idx = fy * FB_W + fx;
    e.in_range = (fx < FB_W) && (fy < FB_H);
    e.addr = m_base + idx / lanes;
    e.lane = idx % lanes;
    e.mode = m_mode;
    e.addr_chk = e.in_range && (m_mode != 3);
    e.ad = ad; e.hs = hs; e.vs = vs;
    return e;
  endfunction

  function automatic logic [23:0] model_rgb(rec_t e);
    logic [31:0] w;
    int px, r, g, b;
    if (!e.ad) return 24'h0;
    if (!e.in_range || e.mode == 3) return BORDER;
    w = mem_word(e.addr);
    if (e.mode == 0) begin
      px = int'((w >> (8 * e.lane)) & 32'hFF);
      r = px / 32; g = (px / 4) % 8; b = px % 4;
      return {8'(r * 32 + r * 4 + r / 2), 8'(g * 32 + g * 4 + g / 2), 8'(b * 85)};
    end else if (e.mode == 1) begin
      px = int'((w >> (16 * e.lane)) & 32'hFFFF);
      r = px / 2048; g = (px / 32) % 64; b = px % 32;
      return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    end else begin
      px = int'((w >> (4 * e.lane)) & 32'hF);
      return {3{8'(px * 17)}};
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pixel cycle: check outputs, answer the memory, drive the next inputs.
  task automatic tick(input int h, input int v, input bit ad, input bit hs, input bit vs,
                      input bit nf, input int md, input logic [31:0] base, input bit rs);
    rec_t e;
    @(negedge clk);
    if (rs && !rst) begin
      rst = 1'b1;
      #1;
      chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_active", {31'b0, active_draw_out}, 32'h0);
      chk("rst_hsync", {31'b0, h_sync_out}, 32'h0);
      chk("rst_vsync", {31'b0, v_sync_out}, 32'h0);
      exp_q.delete();
      repeat (RDL + 3) exp_q.push_back(zero_rec());
    end else begin
      rst = rs;
    end
    e = exp_q[0];
    chk("rgb", {8'h0, red, green, blue}, {8'h0, model_rgb(e)});
    chk("active_out", {31'b0, active_draw_out}, {31'b0, e.ad});
    chk("hsync_out", {31'b0, h_sync_out}, {31'b0, e.hs});
    chk("vsync_out", {31'b0, v_sync_out}, {31'b0, e.vs});
    if (exp_q[RDL + 1].addr_chk) chk("mem_addr", mem_addr, exp_q[RDL + 1].addr);
    mem_rdata = mem_word(hist[0]);
    void'(hist.pop_front());
    hist.push_back(mem_addr);
    void'(exp_q.pop_front());
    exp_q.push_back(rs ? zero_rec() : model_rec(h, v, ad, hs, vs));
    if (rs) begin
      m_mode = 0;
      m_base = BASE0;
    end else if (nf) begin
      m_mode = md;
      m_base = base;
    end
    h_count_in     = 11'(h);
    v_count_in     = 10'(v);
    active_draw_in = ad;
    h_sync_in      = hs;
    v_sync_in      = vs;
    new_frame_in   = nf;
    mode_in        = 2'(md);
    fb_base_in     = base;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[12'h300] = 32'h0049E0FF;
    repeat (RDL + 3) exp_q.push_back(zero_rec());
    repeat (RDL) hist.push_back(32'h0);

    // reset values, then first addresses with default base and RGB332
    repeat (3) tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
    tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tick(4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tick(16, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tick(16, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    idle(6);

    // RGB332 expansion with sync patterns
    tick(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tick(4, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
    tick(8, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0, 1'b0);
    idle(6);

    // RGB565
    mem[12'h300] = 32'h07E0F800;
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, BASE0, 1'b0);
    tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tick(4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    idle(6);

    // GREY4
    mem[12'h300] = 32'h0000000A;
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2, BASE0, 1'b0);
    tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2, BASE0, 1'b0);
    tick(32, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2, BASE0, 1'b0);
    idle(6);

    // new mode/base held off until the frame start
    for (int h = 0; h < 48; h += 4) tick(h, 400, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h800, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h800, 1'b0);
    tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h800, 1'b0);
    tick(4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h800, 1'b0);
    idle(6);

    // border: below the framebuffer, right of it, reserved mode, blanking
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, BASE0, 1'b0);
    tick(0, 640, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tick(1300, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3, BASE0, 1'b0);
    tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tick(8, 8, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    idle(6);

    // random timing, formats and frame starts
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 1599), $urandom_range(0, 749), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
           $urandom_range(0, 3), 32'($urandom_range(0, 4095)), 1'b0);
    end

    // reset in the middle of a frame; shadow must return to defaults
    tick(500, 300, 1'b1, 1'b1, 1'b1, 1'b0, 1, 32'h900, 1'b1);
    tick(504, 300, 1'b1, 1'b1, 1'b1, 1'b0, 1, 32'h900, 1'b1);
    tick(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'h900, 1'b0);
    tick(4, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'h900, 1'b0);
    tick(40, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h900, 1'b0);
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
